hwpe_job_scheduler: RTL and testbench



---
 rtl/hwpe_job_scheduler.sv | 161 ++++++++++++++++
 tb/tb_hwpe_job_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_job_scheduler.sv
// hwpe_job_scheduler: queues core job descriptors and serialises them onto the HWPE control port
module hwpe_job_scheduler #(
  parameter int unsigned NrCores    = 8,
  parameter int unsigned NrRegs     = 6,
  parameter int unsigned QueueDepth = 4,
  parameter logic [31:0] RegBase    = 32'h20,
  parameter int unsigned RetryDelay = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrCores-1:0]                  sub_valid_i,
  output logic [NrCores-1:0]                  sub_ready_o,
  input  logic [NrCores-1:0][NrRegs-1:0][31:0] sub_regs_i,
  output logic                                periph_req_o,
  input  logic                                periph_gnt_i,
  output logic                                periph_we_o,
  output logic [31:0]                         periph_add_o,
  output logic [31:0]                         periph_wdata_o,
  output logic [3:0]                          periph_be_o,
  input  logic                                periph_rvalid_i,
  input  logic [31:0]                         periph_rdata_i,
  input  logic                                hwpe_done_i,
  output logic [NrCores-1:0]                  done_irq_o,
  output logic                                busy_o,
  output logic [$clog2(QueueDepth):0]         level_o,
  output logic                                spurious_o
);
  localparam int CW = NrCores > 1 ? $clog2(NrCores) : 1;
  localparam int AW = $clog2(QueueDepth);
  localparam int LW = AW + 1;
  localparam int IW = NrRegs > 1 ? $clog2(NrRegs) : 1;
  localparam int RW = $clog2(RetryDelay + 1);
  typedef enum logic [2:0] {IDLE, ACQ, ACQ_WAIT, PROG, TRIG, WAIT} state_t;
  state_t state;
  logic [NrRegs-1:0][31:0] q_regs [QueueDepth];
  logic [CW-1:0] q_core [QueueDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rr_ptr, win, idx_c;
  logic [IW-1:0] idx, idx_nx;
  logic [RW-1:0] retry;
  logic found, push, pop, full, wait_rsp, rsp, unused_rdata;

  assign full = level_o == LW'(QueueDepth);
  assign pop = (state == WAIT) & hwpe_done_i;
  assign rsp = wait_rsp & periph_rvalid_i;
  assign idx_nx = idx + 1'b1;
  assign periph_be_o = 4'hF;
  assign unused_rdata = ^periph_rdata_i[30:0];

  always_comb begin
    found = 1'b0;
    win = '0;
    idx_c = '0;
    for (int i = int'(NrCores) - 1; i >= 0; i--) begin
      idx_c = CW'((int'(rr_ptr) + i) % int'(NrCores));
      if (sub_valid_i[idx_c]) begin
        win = idx_c;
        found = 1'b1;
      end
    end
    push = found & ~full & ~rst_i;
    sub_ready_o = '0;
    sub_ready_o[win] = push;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (win == CW'(NrCores - 1)) ? '0 : win + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level_o <= level_o + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_regs[wr_ptr] <= sub_regs_i[win];
      q_core[wr_ptr] <= win;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      periph_req_o <= 1'b0;
      periph_we_o <= 1'b0;
      periph_add_o <= '0;
      periph_wdata_o <= '0;
      wait_rsp <= 1'b0;
      idx <= '0;
      retry <= '0;
      done_irq_o <= '0;
      busy_o <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      done_irq_o <= '0;
      if (hwpe_done_i && state != WAIT) spurious_o <= 1'b1;
      if (periph_req_o && periph_gnt_i) begin
        periph_req_o <= 1'b0;
        wait_rsp <= 1'b1;
      end
      if (rsp) wait_rsp <= 1'b0;
      case (state)
        IDLE: if (level_o != '0) begin
          state <= ACQ;
          busy_o <= 1'b1;
          periph_req_o <= 1'b1;
          periph_we_o <= 1'b0;
          periph_add_o <= 32'h4;
        end
        ACQ: if (rsp) begin
          if (periph_rdata_i[31]) begin
            state <= ACQ_WAIT;
            retry <= '0;
          end else begin
            state <= PROG;
            idx <= '0;
            periph_req_o <= 1'b1;
            periph_we_o <= 1'b1;
            periph_add_o <= RegBase;
            periph_wdata_o <= q_regs[rd_ptr][0];
          end
        end
        ACQ_WAIT: if (retry == RW'(RetryDelay - 1)) begin
          state <= ACQ;
          periph_req_o <= 1'b1;
          periph_we_o <= 1'b0;
          periph_add_o <= 32'h4;
        end else begin
          retry <= retry + 1'b1;
        end
        PROG: if (rsp) begin
          periph_req_o <= 1'b1;
          if (idx == IW'(NrRegs - 1)) begin
            state <= TRIG;
            periph_add_o <= '0;
            periph_wdata_o <= '0;
          end else begin
            idx <= idx_nx;
            periph_add_o <= RegBase + 32'({idx_nx, 2'b00});
            periph_wdata_o <= q_regs[rd_ptr][idx_nx];
          end
        end
        TRIG: if (rsp) state <= WAIT;
        WAIT: if (hwpe_done_i) begin
          state <= IDLE;
          busy_o <= 1'b0;
          done_irq_o[q_core[rd_ptr]] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hwpe_job_scheduler.sv
// tb_hwpe_job_scheduler: directed self-checking bench for hwpe_job_scheduler
module tb_hwpe_job_scheduler;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] sub_valid_i = '0;
  logic [7:0] sub_ready_o;
  logic [7:0][5:0][31:0] sub_regs_i;
  logic periph_req_o, periph_we_o;
  logic periph_gnt_i = 1'b0;
  logic periph_rvalid_i = 1'b0;
  logic hwpe_done_i = 1'b0;
  logic [31:0] periph_add_o, periph_wdata_o;
  logic [31:0] periph_rdata_i = '0;
  logic [3:0] periph_be_o;
  logic [7:0] done_irq_o;
  logic busy_o, spurious_o;
  logic [2:0] level_o;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] tr_add[$];
  logic [31:0] tr_data[$];
  logic tr_we[$];
  int tr_cyc[$];
  int acc[$];
  logic [31:0] acq_q[$];
  int stall_at = -1;
  int stall_n = 0;
  bit stalling = 1'b0;
  bit pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] st_add = '0;
  logic [31:0] st_data = '0;
  logic [7:0] r;
  int k;
  logic [31:0] exp_a, exp_d;
  logic [31:0] t3_reg0 [5] = '{32'h2001, 32'h3001, 32'h0001, 32'h5001, 32'h6001};

  hwpe_job_scheduler dut (
    .clk_i(clk), .rst_i(rst_i),
    .sub_valid_i(sub_valid_i), .sub_ready_o(sub_ready_o), .sub_regs_i(sub_regs_i),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_we_o(periph_we_o),
    .periph_add_o(periph_add_o), .periph_wdata_o(periph_wdata_o), .periph_be_o(periph_be_o),
    .periph_rvalid_i(periph_rvalid_i), .periph_rdata_i(periph_rdata_i),
    .hwpe_done_i(hwpe_done_i), .done_irq_o(done_irq_o), .busy_o(busy_o),
    .level_o(level_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    for (int c = 0; c < 8; c++) if (!rst_i && sub_valid_i[c] && sub_ready_o[c]) acc.push_back(c);
  end

  initial forever begin
    @(negedge clk);
    periph_rvalid_i = pend;
    periph_rdata_i = pend_data;
    if (pend) chk("one_outstanding", periph_req_o, 0);
    pend = 1'b0;
    periph_gnt_i = 1'b0;
    if (periph_req_o && !rst_i) begin
      if (tr_add.size() == stall_at && stall_n > 0) begin
        if (stalling) begin
          chk("stall_add", periph_add_o, st_add);
          chk("stall_data", periph_wdata_o, st_data);
        end else begin
          st_add = periph_add_o;
          st_data = periph_wdata_o;
          stalling = 1'b1;
        end
        stall_n--;
      end else begin
        if (stalling) begin
          chk("stall_add_gnt", periph_add_o, st_add);
          chk("stall_data_gnt", periph_wdata_o, st_data);
        end
        stalling = 1'b0;
        periph_gnt_i = 1'b1;
        tr_add.push_back(periph_add_o);
        tr_data.push_back(periph_wdata_o);
        tr_we.push_back(periph_we_o);
        tr_cyc.push_back(cyc);
        pend = 1'b1;
        pend_data = 32'h0;
        if (periph_we_o) pend_data = 32'hDEAD_BEEF;
        else if (acq_q.size() > 0) pend_data = acq_q.pop_front();
      end
    end
  end

  task automatic clear_log();
    tr_add.delete();
    tr_data.delete();
    tr_we.delete();
    tr_cyc.delete();
    acc.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sub_valid_i = '0;
    hwpe_done_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    clear_log();
  endtask

  task automatic wait_tr(input int n, input string tag);
    int w = 0;
    while (tr_add.size() < n && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk(tag, tr_add.size() >= n, 1);
  endtask

  task automatic submit(input int c);
    int w = 0;
    sub_valid_i[c] = 1'b1;
    #1;
    while (!sub_ready_o[c] && w < 300) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("submit_ready", sub_ready_o[c], 1);
    @(negedge clk);
    sub_valid_i[c] = 1'b0;
  endtask

  task automatic finish_job(input int n, input logic [7:0] irq, input string tag);
    wait_tr(n, {tag, "_tr"});
    repeat (3) @(negedge clk);
    hwpe_done_i = 1'b1;
    @(negedge clk);
    hwpe_done_i = 1'b0;
    chk({tag, "_irq"}, done_irq_o, irq);
    @(negedge clk);
    chk({tag, "_irq_clr"}, done_irq_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 6; i++)
        sub_regs_i[c][i] = (c == 3) ? 32'(i + 1) : 32'(32'h1000 * (c + 1) + i + 1);
    do_reset();
    chk("rst_req", periph_req_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_irq", done_irq_o, 0);
    chk("rst_spurious", spurious_o, 0);
    chk("rst_ready", sub_ready_o, 0);
    chk("be", periph_be_o, 4'hF);

    submit(3);
    chk("t1_level_n1", level_o, 1);
    chk("t1_busy_n1", busy_o, 0);
    chk("t1_req_n1", periph_req_o, 0);
    @(negedge clk);
    chk("t1_req_n2", periph_req_o, 1);
    chk("t1_add_n2", periph_add_o, 32'h4);
    chk("t1_busy_n2", busy_o, 1);
    finish_job(8, 8'h08, "t1");
    for (int j = 0; j < 8; j++) begin
      exp_a = (j == 0) ? 32'h4 : (j == 7) ? 32'h0 : 32'(32'h20 + 4 * (j - 1));
      exp_d = (j == 7) ? 32'h0 : 32'(j);
      chk("t1_add", tr_add[j], exp_a);
      chk("t1_we", tr_we[j], j != 0);
      if (j > 0) chk("t1_data", tr_data[j], exp_d);
    end
    chk("t1_ntr", tr_add.size(), 8);
    chk("t1_busy_end", busy_o, 0);
    chk("t1_level_end", level_o, 0);
    chk("t1_spurious", spurious_o, 0);

    do_reset();
    sub_valid_i = 8'b1000_0101;
    k = 0;
    while (sub_valid_i != 0 && k < 20) begin
      #1;
      r = sub_ready_o;
      chk("rr_onehot", $countones(r) <= 1, 1);
      @(negedge clk);
      sub_valid_i &= ~r;
      k++;
    end
    chk("rr_nacc", acc.size(), 3);
    chk("rr_acc0", acc[0], 0);
    chk("rr_acc1", acc[1], 2);
    chk("rr_acc2", acc[2], 7);
    chk("rr_level", level_o, 3);
    finish_job(8, 8'h01, "t2a");
    finish_job(16, 8'h04, "t2b");
    finish_job(24, 8'h80, "t2c");
    chk("t2_core2_reg0", tr_data[9], 32'h3001);
    chk("t2_core7_reg5", tr_data[22], 32'h8006);
    chk("t2_level_end", level_o, 0);

    do_reset();
    sub_valid_i = 8'b0011_1110;
    k = 0;
    while (sub_valid_i != 8'h20 && k < 20) begin
      #1;
      r = sub_ready_o;
      @(negedge clk);
      sub_valid_i &= ~r;
      k++;
    end
    wait_tr(8, "t3_tr1");
    repeat (3) @(negedge clk);
    chk("t3_level_full", level_o, 4);
    chk("t3_ready_full", sub_ready_o, 0);
    hwpe_done_i = 1'b1;
    #1;
    chk("t3_ready_pop_cycle", sub_ready_o, 0);
    @(negedge clk);
    hwpe_done_i = 1'b0;
    #1;
    chk("t3_irq1", done_irq_o, 8'h02);
    chk("t3_ready_after_pop", sub_ready_o, 8'h20);
    chk("t3_level_after_pop", level_o, 3);
    @(negedge clk);
    sub_valid_i = '0;
    chk("t3_level_refill", level_o, 4);
    finish_job(16, 8'h04, "t3b");
    finish_job(24, 8'h08, "t3c");
    finish_job(32, 8'h10, "t3d");
    finish_job(40, 8'h20, "t3e");
    for (int j = 0; j < 5; j++) chk("t3_reg0", tr_data[8 * j + 1], t3_reg0[j]);
    chk("t3_nacc", acc.size(), 5);
    for (int j = 0; j < 5; j++) chk("t3_acc", acc[j], j + 1);
    chk("t3_ntr", tr_add.size(), 40);
    chk("t3_level_end", level_o, 0);

    do_reset();
    acq_q = '{32'h8000_0000, 32'h8000_0000, 32'h1};
    submit(6);
    finish_job(10, 8'h40, "t4");
    for (int j = 0; j < 3; j++) begin
      chk("t4_acq_add", tr_add[j], 32'h4);
      chk("t4_acq_we", tr_we[j], 0);
    end
    chk("t4_gap1", tr_cyc[1] - tr_cyc[0] - 1 >= 4, 1);
    chk("t4_gap2", tr_cyc[2] - tr_cyc[1] - 1 >= 4, 1);
    chk("t4_prog_add", tr_add[3], 32'h20);
    chk("t4_prog_data", tr_data[3], 32'h7001);
    chk("t4_trig_add", tr_add[9], 32'h0);
    chk("t4_ntr", tr_add.size(), 10);

    do_reset();
    stall_at = 2;
    stall_n = 5;
    submit(5);
    k = 0;
    while (!stalling && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t5_stalling", stalling, 1);
    hwpe_done_i = 1'b1;
    @(negedge clk);
    hwpe_done_i = 1'b0;
    chk("t5_spurious", spurious_o, 1);
    chk("t5_irq_none", done_irq_o, 0);
    chk("t5_req_held", periph_req_o, 1);
    chk("t5_add_held", periph_add_o, 32'h24);
    chk("t5_data_held", periph_wdata_o, 32'h6002);
    finish_job(8, 8'h20, "t5");
    chk("t5_add2", tr_add[2], 32'h24);
    chk("t5_data2", tr_data[2], 32'h6002);
    chk("t5_spurious_sticky", spurious_o, 1);
    chk("t5_ntr", tr_add.size(), 8);
    stall_at = -1;

    do_reset();
    chk("t6_spurious_cleared", spurious_o, 0);
    submit(4);
    wait_tr(4, "t6_tr");
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("t6_req", periph_req_o, 0);
    chk("t6_level", level_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_irq", done_irq_o, 0);
    @(negedge clk);
    clear_log();
    submit(4);
    finish_job(8, 8'h10, "t6b");
    chk("t6_acq_add", tr_add[0], 32'h4);
    chk("t6_acq_we", tr_we[0], 0);
    chk("t6_reg0", tr_data[1], 32'h5001);
    chk("t6_ntr", tr_add.size(), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
